// File: rtl/bitty_pkg.sv
// Shared constants for the bitty fetch path: instruction width and the
// fetch FSM state encoding.
package bitty_pkg;

    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_LATCH     = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_FINISH    = 3'd5
    } fetch_state_e;

endpackage

// File: rtl/bitty_fetch_unit_reg.sv
// Load-enabled register with asynchronous active-low clear; holds the
// fetched instruction word.
module bitty_fetch_unit_reg #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/bitty_fetch_unit.sv
// Fetch/issue sequencer for bitty_core: reads one instruction per step,
// issues it with a run pulse and waits for done. Optional done watchdog
// enabled by defining BITTY_FETCH_TIMEOUT_EN.
module bitty_fetch_unit
    import bitty_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int PROG_LEN = 256,
    parameter int TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic               run,
    input  logic               done,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               finished,
    output logic               timeout_err
);

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              latch_en;
    logic              timeout_hit;

`ifdef BITTY_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;

    assign timeout_hit = (state_q == ST_WAIT_DONE) && !done &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));

    // Counter restarts for every instruction; the flag clears on a new program.
    always_comb begin
        cnt_d  = (state_q == ST_WAIT_DONE) ? cnt_q + 1'b1 : '0;
        terr_d = terr_q;
        if ((state_q == ST_IDLE || state_q == ST_FINISH) && start) begin
            terr_d = 1'b0;
        end else if (timeout_hit) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_LATCH;
            ST_LATCH: begin
                latch_en = 1'b1;
                state_d  = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                // pc stops at the last address so it can never wrap.
                if (done) begin
                    if (pc_q == LAST_PC) begin
                        state_d = ST_FINISH;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_READ;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_FINISH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    bitty_fetch_unit_reg #(
        .W (INSTR_W)
    ) u_instr_reg (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (latch_en),
        .d_i    (mem_data),
        .q_o    (instruction)
    );

    assign mem_addr = pc_q;
    assign mem_rd   = (state_q == ST_READ);
    assign run      = (state_q == ST_ISSUE);
    assign pc       = pc_q;
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign finished = (state_q == ST_FINISH);

endmodule
